decode_ex_pipe: RTL and testbench
=================================

DECODE_EX_PIPE -- requirements
Module: decode_ex_pipe

Interface
REQ-001 Parameter XLEN, default 32, SHALL set the data path width (operands, immediate, PC, PC+4, writeback data).
REQ-002 Parameter RA_W, default 5, SHALL set the register-address width.
REQ-003 Parameter CTRL_W, default 8, SHALL set the packed control width: {RegWrite, ALUSrc, MemWrite, ResultSrc, Branch, ALUControl[2:0]}.
REQ-004 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst  in  1  SHALL be the reset: asynchronous, active-high.
REQ-006 in_valid / in_ready  in / out  1 / 1  SHALL be the decode-side handshake.
REQ-007 in_ctrl, in_rs1_addr, in_rs2_addr, in_rd_addr  in  CTRL_W, RA_W x3  SHALL carry decoded control and register addresses.
REQ-008 in_rs1_data, in_rs2_data, in_imm, in_pc, in_pc_plus4  in  XLEN each  SHALL carry register-file reads, sign-extended immediate and PCs.
REQ-009 out_valid / out_ready  out / in  1 / 1  SHALL be the execute-side handshake.
REQ-010 out_ctrl, out_rs1_addr, out_rs2_addr, out_rd_addr, out_rs1_data, out_rs2_data, out_imm, out_pc, out_pc_plus4  out  SHALL mirror the input payload widths.
REQ-011 flush  in  1  SHALL discard all held entries (branch taken).
REQ-012 wb_we, wb_rd, wb_data  in  1, RA_W, XLEN  SHALL carry the writeback port, used only when the bypass is compiled in.

Function
REQ-013 The block SHALL be a two-entry elastic buffer (main + skid) with states EMPTY, ONE and TWO.
REQ-014 in_ready SHALL equal NOT skid_valid, driven only from a register with no combinational path from out_ready.
REQ-015 out_valid SHALL equal main_valid; the out_* payload SHALL come from the main entry.
REQ-016 A push SHALL occur on a cycle with in_valid AND in_ready; a pop SHALL occur on a cycle with out_valid AND out_ready.
REQ-017 EMPTY: push SHALL load main and go to ONE.
REQ-018 ONE: push without pop SHALL load skid and go to TWO; pop without push SHALL go to EMPTY; simultaneous push and pop SHALL load main with the new entry and stay in ONE.
REQ-019 TWO: pop SHALL move skid to main and go to ONE; no push is possible in TWO.
REQ-020 Latency SHALL be one cycle: data pushed at edge N is on out_* with out_valid=1 after edge N.
REQ-021 While out_valid=0, out_ctrl SHALL be all zero (bubble), making RegWrite and MemWrite inert; the other out_* fields are don't-care.
REQ-022 flush SHALL have priority over push and pop: next state EMPTY, any same-cycle input dropped, in_ready=1 on the next cycle.
REQ-023 Entries SHALL never be duplicated, reordered or lost, except through flush.

Reset
REQ-024 While rst=1, state SHALL be EMPTY, all payload registers zero, out_valid=0, out_ctrl=0 and in_ready=1; pushes SHALL be ignored.
REQ-025 rst asserted mid-operation SHALL drop all entries immediately, without waiting for a clock edge.

Configuration
REQ-026 With macro DECODE_EX_BYPASS_EN defined, a push with wb_we=1, wb_rd!=0 and wb_rd equal to in_rs1_addr (respectively in_rs2_addr) SHALL capture wb_data instead of in_rs1_data (in_rs2_data).
REQ-027 With DECODE_EX_BYPASS_EN defined, a held main or skid entry whose rs1/rs2 address matches a valid writeback (wb_we=1, wb_rd!=0) SHALL update that operand to wb_data on the same edge.
REQ-028 Without DECODE_EX_BYPASS_EN, the wb_* ports SHALL be ignored and operands captured unchanged; ports and timing are identical in both builds.

Verification
REQ-029 Reset: pulse rst asynchronously between edges -> out_valid=0, out_ctrl=0 and in_ready=1 immediately.
REQ-030 Streaming: push 8 entries (pc=0x0,0x4,...) with out_ready=1 -> out_pc sequence 0x0..0x1C, one per cycle, in_ready stays 1.
REQ-031 Backpressure: out_ready=0 with 3 pushes offered -> two accepted, in_ready=0 in TWO; set out_ready=1 -> both emerge in order, third accepted on the first free cycle.
REQ-032 Flush: in TWO, assert flush together with in_valid=1 -> next cycle out_valid=0, in_ready=1, and none of the three entries ever appear.
REQ-033 Bypass (macro on): push rs1=5, in_rs1_data=0x11 with wb_we=1, wb_rd=5, wb_data=0xAA -> out_rs1_data=0xAA; same with wb_rd=0 -> 0x11; macro off -> 0x11 in both cases.
REQ-034 Stalled bypass (macro on): hold an entry with rs2=7 under out_ready=0, then write wb_rd=7, wb_data=0x55 -> out_rs2_data=0x55 on the next cycle.

Source files
------------

// File: rtl/decode_ex_pipe.sv
// ---------------------------------------------------------------------------
// decode_ex_pipe -- decode-to-execute pipeline register as a two-entry
// elastic buffer (main + skid).
//
// The main entry drives the execute side. The skid entry absorbs the one
// extra push that can arrive while execute stalls. Because of the skid entry,
// in_ready comes straight from a flop and has no combinational path from
// out_ready.
//
// Optional build macro:
//   DECODE_EX_BYPASS_EN -- forward the writeback port (wb_*) into operands.
//                          Forwarding applies when an entry is captured and
//                          while it is held. Without the macro, wb_* is
//                          ignored. Ports and timing are the same in both
//                          builds.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   decode-side handshake
//   in_*                decoded payload: ctrl {RegWrite, ALUSrc, MemWrite,
//                       ResultSrc, Branch, ALUControl[2:0]}, rs1/rs2/rd
//                       addresses, rs1/rs2 data, immediate, pc, pc+4
//   out_valid/out_ready execute-side handshake
//   out_*               payload of the main entry (out_ctrl is zero when idle)
//   flush               discard every held entry (branch taken)
//   wb_we/wb_rd/wb_data writeback port, used for operand forwarding
// ---------------------------------------------------------------------------
module decode_ex_pipe #(
    parameter int XLEN   = 32,
    parameter int RA_W   = 5,
    parameter int CTRL_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    // decode side
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [RA_W-1:0]   in_rs1_addr,
    input  logic [RA_W-1:0]   in_rs2_addr,
    input  logic [RA_W-1:0]   in_rd_addr,
    input  logic [XLEN-1:0]   in_rs1_data,
    input  logic [XLEN-1:0]   in_rs2_data,
    input  logic [XLEN-1:0]   in_imm,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [XLEN-1:0]   in_pc_plus4,
    // execute side
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [RA_W-1:0]   out_rs1_addr,
    output logic [RA_W-1:0]   out_rs2_addr,
    output logic [RA_W-1:0]   out_rd_addr,
    output logic [XLEN-1:0]   out_rs1_data,
    output logic [XLEN-1:0]   out_rs2_data,
    output logic [XLEN-1:0]   out_imm,
    output logic [XLEN-1:0]   out_pc,
    output logic [XLEN-1:0]   out_pc_plus4,
    // control / writeback
    input  logic              flush,
    input  logic              wb_we,
    input  logic [RA_W-1:0]   wb_rd,
    input  logic [XLEN-1:0]   wb_data
);

    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_ONE   = 2'b01;
    localparam logic [1:0] ST_TWO   = 2'b10;

    // Non-operand payload packed as {ctrl, rs1a, rs2a, rda, imm, pc, pc4}.
    // Operand data is stored separately so that it can be forwarded.
    localparam int MW       = CTRL_W + 3*RA_W + 3*XLEN;
    localparam int RS1A_LSB = 3*XLEN + 2*RA_W;
    localparam int RS2A_LSB = 3*XLEN + RA_W;

    logic [1:0]      state_q, state_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;

    logic [MW-1:0]   main_meta_q, main_meta_d;
    logic [XLEN-1:0] main_rs1_q, main_rs1_d;
    logic [XLEN-1:0] main_rs2_q, main_rs2_d;
    logic [MW-1:0]   skid_meta_q, skid_meta_d;
    logic [XLEN-1:0] skid_rs1_q, skid_rs1_d;
    logic [XLEN-1:0] skid_rs2_q, skid_rs2_d;

    logic [MW-1:0]   in_meta;
    logic [CTRL_W-1:0] main_ctrl;
    logic            push, pop;
    logic            wb_vld;

    // ------------------------------------------------------------------
    // Writeback forwarding qualifier. x0 is hard-wired zero, so it is never
    // forwarded.
    // ------------------------------------------------------------------
`ifdef DECODE_EX_BYPASS_EN
    assign wb_vld = wb_we && (wb_rd != '0);
`else
    assign wb_vld = 1'b0;
    logic unused_wb;
    assign unused_wb = wb_we;
`endif

    function automatic logic [XLEN-1:0] fwd(input logic [RA_W-1:0] addr,
                                            input logic [XLEN-1:0] data);
        return (wb_vld && (wb_rd == addr)) ? wb_data : data;
    endfunction

    assign in_meta = {in_ctrl, in_rs1_addr, in_rs2_addr, in_rd_addr,
                      in_imm, in_pc, in_pc_plus4};

    // Both handshakes use registered flags only.
    assign push = in_valid && in_ready_q;
    assign pop  = out_valid_q && out_ready;

    // ------------------------------------------------------------------
    // Next-state logic. A held operand is refreshed from writeback every
    // cycle. Any move or load below therefore starts from the forwarded
    // value.
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        main_meta_d = main_meta_q;
        main_rs1_d  = fwd(main_meta_q[RS1A_LSB +: RA_W], main_rs1_q);
        main_rs2_d  = fwd(main_meta_q[RS2A_LSB +: RA_W], main_rs2_q);
        skid_meta_d = skid_meta_q;
        skid_rs1_d  = fwd(skid_meta_q[RS1A_LSB +: RA_W], skid_rs1_q);
        skid_rs2_d  = fwd(skid_meta_q[RS2A_LSB +: RA_W], skid_rs2_q);

        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (push) begin
                        main_meta_d = in_meta;
                        main_rs1_d  = fwd(in_rs1_addr, in_rs1_data);
                        main_rs2_d  = fwd(in_rs2_addr, in_rs2_data);
                        state_d     = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (push && !pop) begin
                        skid_meta_d = in_meta;
                        skid_rs1_d  = fwd(in_rs1_addr, in_rs1_data);
                        skid_rs2_d  = fwd(in_rs2_addr, in_rs2_data);
                        state_d     = ST_TWO;
                    end else if (push && pop) begin
                        main_meta_d = in_meta;
                        main_rs1_d  = fwd(in_rs1_addr, in_rs1_data);
                        main_rs2_d  = fwd(in_rs2_addr, in_rs2_data);
                    end else if (pop) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    // in_ready is low here, so only a pop can happen.
                    if (pop) begin
                        main_meta_d = skid_meta_q;
                        main_rs1_d  = fwd(skid_meta_q[RS1A_LSB +: RA_W], skid_rs1_q);
                        main_rs2_d  = fwd(skid_meta_q[RS2A_LSB +: RA_W], skid_rs2_q);
                        state_d     = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end

        in_ready_d  = (state_d != ST_TWO);
        out_valid_d = (state_d != ST_EMPTY);
    end

    // ------------------------------------------------------------------
    // State and payload registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            main_meta_q <= '0;
            main_rs1_q  <= '0;
            main_rs2_q  <= '0;
            skid_meta_q <= '0;
            skid_rs1_q  <= '0;
            skid_rs2_q  <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            main_meta_q <= main_meta_d;
            main_rs1_q  <= main_rs1_d;
            main_rs2_q  <= main_rs2_d;
            skid_meta_q <= skid_meta_d;
            skid_rs1_q  <= skid_rs1_d;
            skid_rs2_q  <= skid_rs2_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs. ctrl is forced to zero as a bubble when nothing is valid, so
    // RegWrite and MemWrite cannot fire.
    // ------------------------------------------------------------------
    assign {main_ctrl, out_rs1_addr, out_rs2_addr, out_rd_addr,
            out_imm, out_pc, out_pc_plus4} = main_meta_q;

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign out_ctrl     = out_valid_q ? main_ctrl : '0;
    assign out_rs1_data = main_rs1_q;
    assign out_rs2_data = main_rs2_q;

endmodule

// File: tb/tb_decode_ex_pipe.sv
// ---------------------------------------------------------------------------
// tb_decode_ex_pipe -- scoreboard bench for decode_ex_pipe.
// Each accepted push records the entry it expects into a queue. Each pop
// compares the DUT output with the head of that queue. The expected entry
// models writeback forwarding whenever DECODE_EX_BYPASS_EN is defined.
// ---------------------------------------------------------------------------
module tb_decode_ex_pipe;

`ifdef DECODE_EX_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk, rst;
    logic        in_valid, in_ready;
    logic [7:0]  in_ctrl;
    logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
    logic [31:0] in_rs1_data, in_rs2_data, in_imm, in_pc, in_pc_plus4;
    logic        out_valid, out_ready;
    logic [7:0]  out_ctrl;
    logic [4:0]  out_rs1_addr, out_rs2_addr, out_rd_addr;
    logic [31:0] out_rs1_data, out_rs2_data, out_imm, out_pc, out_pc_plus4;
    logic        flush, wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    decode_ex_pipe #(.XLEN(32), .RA_W(5), .CTRL_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_ctrl      (in_ctrl),
        .in_rs1_addr  (in_rs1_addr),
        .in_rs2_addr  (in_rs2_addr),
        .in_rd_addr   (in_rd_addr),
        .in_rs1_data  (in_rs1_data),
        .in_rs2_data  (in_rs2_data),
        .in_imm       (in_imm),
        .in_pc        (in_pc),
        .in_pc_plus4  (in_pc_plus4),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_ctrl     (out_ctrl),
        .out_rs1_addr (out_rs1_addr),
        .out_rs2_addr (out_rs2_addr),
        .out_rd_addr  (out_rd_addr),
        .out_rs1_data (out_rs1_data),
        .out_rs2_data (out_rs2_data),
        .out_imm      (out_imm),
        .out_pc       (out_pc),
        .out_pc_plus4 (out_pc_plus4),
        .flush        (flush),
        .wb_we        (wb_we),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data)
    );

    typedef struct {
        logic [31:0] pc, pc4, imm, rs1d, rs2d;
        logic [7:0]  ctrl;
        logic [4:0]  rs1a, rs2a, rd;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
        flush    = 1'b0;
        wb_we    = 1'b0;
        wb_rd    = '0;
        wb_data  = '0;
    endtask

    task automatic offer(input logic [31:0] pc, input logic [4:0] rs1a, input logic [31:0] rs1d,
                         input logic [4:0] rs2a, input logic [31:0] rs2d);
        in_valid    = 1'b1;
        in_pc       = pc;
        in_pc_plus4 = pc + 32'd4;
        in_imm      = ~pc;
        in_ctrl     = {1'b1, pc[8:2]};
        in_rd_addr  = pc[6:2] ^ 5'h15;
        in_rs1_addr = rs1a;
        in_rs1_data = rs1d;
        in_rs2_addr = rs2a;
        in_rs2_data = rs2d;
    endtask

    // Model one clock cycle. Observation happens at the falling edge, while
    // inputs and outputs are stable. The task returns 1 ns after the rising
    // edge, which is the point where the next stimulus is driven.
    task automatic step();
        exp_t e;
        logic wbv;
        @(negedge clk);
        wbv = BYP && wb_we && (wb_rd != 5'd0);
        if (!rst) begin
            if (flush) begin
                q.delete();
            end else begin
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        check("spurious_out", {63'd0, out_valid}, 64'd0);
                    end else begin
                        e = q.pop_front();
                        check("out_pc",   {32'd0, out_pc},       {32'd0, e.pc});
                        check("out_ctrl", {56'd0, out_ctrl},     {56'd0, e.ctrl});
                        check("out_rs1d", {32'd0, out_rs1_data}, {32'd0, e.rs1d});
                        check("out_rs2d", {32'd0, out_rs2_data}, {32'd0, e.rs2d});
                        check("out_imm",  {32'd0, out_imm},      {32'd0, e.imm});
                        check("out_pc4",  {32'd0, out_pc_plus4}, {32'd0, e.pc4});
                        check("out_rd",   {59'd0, out_rd_addr},  {59'd0, e.rd});
                    end
                end
                // Entries still held see this cycle's writeback.
                if (wbv) begin
                    foreach (q[i]) begin
                        if (q[i].rs1a == wb_rd) q[i].rs1d = wb_data;
                        if (q[i].rs2a == wb_rd) q[i].rs2d = wb_data;
                    end
                end
                if (in_valid && in_ready) begin
                    e.pc   = in_pc;
                    e.pc4  = in_pc_plus4;
                    e.imm  = in_imm;
                    e.ctrl = in_ctrl;
                    e.rd   = in_rd_addr;
                    e.rs1a = in_rs1_addr;
                    e.rs2a = in_rs2_addr;
                    e.rs1d = (wbv && wb_rd == in_rs1_addr) ? wb_data : in_rs1_data;
                    e.rs2d = (wbv && wb_rd == in_rs2_addr) ? wb_data : in_rs2_data;
                    q.push_back(e);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        idle();
        out_ready = 1'b1;
        for (int i = 0; i < 6 && q.size() != 0; i++) step();
        check({tag, "_left"}, q.size(), 0);
        check({tag, "_idle_valid"}, {63'd0, out_valid}, 64'd0);
    endtask

    initial begin
        rst       = 1'b1;
        out_ready = 1'b0;
        in_ctrl = '0; in_rs1_addr = '0; in_rs2_addr = '0; in_rd_addr = '0;
        in_rs1_data = '0; in_rs2_data = '0; in_imm = '0; in_pc = '0; in_pc_plus4 = '0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_ctrl",  {56'd0, out_ctrl},  64'd0);
        check("rst_in_ready",  {63'd0, in_ready},  64'd1);
        check("rst_out_pc",    {32'd0, out_pc},    64'd0);
        rst = 1'b0;

        // Streaming: 8 back-to-back pushes with the consumer always ready.
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            offer(32'(i * 4), 5'(i + 1), 32'h1000 + 32'(i), 5'(i + 9), 32'h2000 + 32'(i));
            step();
            check("stream_in_ready",  {63'd0, in_ready},  64'd1);
            check("stream_out_valid", {63'd0, out_valid}, 64'd1);
        end
        drain("stream");

        // Asynchronous reset pulse mid-operation, between clock edges.
        out_ready = 1'b0;
        offer(32'h40, 5'd1, 32'h1, 5'd2, 32'h2); step();
        offer(32'h44, 5'd1, 32'h1, 5'd2, 32'h2); step();
        check("pre_rst_in_ready", {63'd0, in_ready}, 64'd0);
        idle();
        #2 rst = 1'b1;
        #1;
        check("arst_out_valid", {63'd0, out_valid}, 64'd0);
        check("arst_out_ctrl",  {56'd0, out_ctrl},  64'd0);
        check("arst_in_ready",  {63'd0, in_ready},  64'd1);
        q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (2) step();
        check("post_rst_valid", {63'd0, out_valid}, 64'd0);

        // Backpressure: three entries offered while the consumer stalls.
        out_ready = 1'b0;
        offer(32'h100, 5'd3, 32'hA1, 5'd4, 32'hB1); step();
        offer(32'h104, 5'd3, 32'hA2, 5'd4, 32'hB2); step();
        check("bp_full_in_ready", {63'd0, in_ready}, 64'd0);
        offer(32'h108, 5'd3, 32'hA3, 5'd4, 32'hB3); step();
        check("bp_still_full", {63'd0, in_ready}, 64'd0);
        check("bp_head_pc",    {32'd0, out_pc},   64'h100);
        out_ready = 1'b1;
        step();
        check("bp_free_in_ready", {63'd0, in_ready}, 64'd1);
        step();
        in_valid = 1'b0;
        step();
        drain("bp");

        // Flush in TWO with a simultaneous push: all three entries vanish.
        out_ready = 1'b0;
        offer(32'h200, 5'd6, 32'hC1, 5'd8, 32'hD1); step();
        offer(32'h204, 5'd6, 32'hC2, 5'd8, 32'hD2); step();
        check("fl_full_in_ready", {63'd0, in_ready}, 64'd0);
        offer(32'h208, 5'd6, 32'hC3, 5'd8, 32'hD3);
        flush = 1'b1;
        step();
        idle();
        check("fl_out_valid", {63'd0, out_valid}, 64'd0);
        check("fl_in_ready",  {63'd0, in_ready},  64'd1);
        check("fl_out_ctrl",  {56'd0, out_ctrl},  64'd0);
        out_ready = 1'b1;
        repeat (3) step();
        check("fl_nothing_out", {63'd0, out_valid}, 64'd0);

        // Forwarding on capture.
        out_ready = 1'b0;
        offer(32'h300, 5'd5, 32'h11, 5'd9, 32'h22);
        wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'hAA;
        step();
        idle();
        check("byp_hit_rs1", {32'd0, out_rs1_data}, BYP ? 64'hAA : 64'h11);
        drain("byp_hit");

        out_ready = 1'b0;
        offer(32'h304, 5'd5, 32'h11, 5'd9, 32'h22);
        wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'hAA;
        step();
        idle();
        check("byp_rd0_rs1", {32'd0, out_rs1_data}, 64'h11);
        drain("byp_rd0");

        out_ready = 1'b0;
        offer(32'h308, 5'd0, 32'h11, 5'd9, 32'h22);
        wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'hAA;
        step();
        idle();
        check("byp_x0_rs1", {32'd0, out_rs1_data}, 64'h11);
        drain("byp_x0");

        // Forwarding into held entries (main and skid both stalled).
        out_ready = 1'b0;
        offer(32'h310, 5'd3, 32'h44, 5'd7, 32'h33); step();
        offer(32'h314, 5'd3, 32'h45, 5'd7, 32'h66); step();
        idle();
        wb_we = 1'b1; wb_rd = 5'd7; wb_data = 32'h55;
        step();
        idle();
        check("stall_byp_rs2", {32'd0, out_rs2_data}, BYP ? 64'h55 : 64'h33);
        check("stall_byp_rs1", {32'd0, out_rs1_data}, 64'h44);
        drain("stall_byp");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
